ahbram_master_arb: RTL

Two-requester round-robin arbiter and AHB-Lite master sequencer placed in front of the AHB RAM slave. Each requester presents simple single-beat read/write commands. The block grants one requester at a time and runs the command as an AHB-Lite SINGLE transfer, honouring HREADY wait states and two-cycle ERROR responses. It returns read data and status tagged with the requester ID. It is the sole master on the RAM's AHB port.

---
 rtl/ahbram_master_arb_if.sv | 57 +++++
 rtl/ahbram_master_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ahbram_master_arb_if.sv
// Bundle of requester-side command/response signals and the AHB-Lite
// master port of ahbram_master_arb.
//
// Handshake: a requester raises rq_valid[i] together with its command fields
// and holds them unchanged until rq_ready[i] is seen high. The command is
// transferred on the rising edge where rq_valid[i] && rq_ready[i]. rq_ready
// is a one-hot strobe and never depends on a later cycle. Responses are
// push-only: rs_valid pulses for exactly one cycle with no back-pressure, and
// rs_id/rs_rdata/rs_err stay stable until the next pulse.
interface ahbram_master_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // requester command side
  logic [1:0]             rq_valid;
  logic [1:0]             rq_write;
  logic [1:0][1:0]        rq_size;
  logic [1:0][ADDR_W-1:0] rq_addr;
  logic [1:0][DATA_W-1:0] rq_wdata;
  logic [1:0]             rq_ready;

  // response side
  logic                   rs_valid;
  logic                   rs_id;
  logic [DATA_W-1:0]      rs_rdata;
  logic                   rs_err;

  // AHB-Lite master port
  logic [ADDR_W-1:0]      haddr;
  logic [1:0]             htrans;
  logic                   hwrite;
  logic [2:0]             hsize;
  logic [2:0]             hburst;
  logic [3:0]             hprot;
  logic [DATA_W-1:0]      hwdata;
  logic [DATA_W-1:0]      hrdata;
  logic                   hready;
  logic                   hresp;

  // arbiter / sequencer side
  modport master (
    input  rq_valid, rq_write, rq_size, rq_addr, rq_wdata,
    output rq_ready,
    output rs_valid, rs_id, rs_rdata, rs_err,
    output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  // requesters plus the RAM slave, seen from outside the block
  modport slave (
    output rq_valid, rq_write, rq_size, rq_addr, rq_wdata,
    input  rq_ready,
    input  rs_valid, rs_id, rs_rdata, rs_err,
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahbram_master_arb.sv
// Two-requester round-robin arbiter feeding a non-pipelined AHB-Lite master
// sequencer. One SINGLE transfer is in flight at a time; misaligned or
// illegal-size commands are answered with an error without touching AHB.
module ahbram_master_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  ahbram_master_arb_if.master bus,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_REJ  = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0]        state;
  logic [1:0]        state_nxt;

  // ID of the requester granted most recently; resets to 1 so that
  // requester 0 wins the first contention.
  logic              last_grant;

  logic              any_req;
  logic              win_id;
  logic              accept;
  logic [1:0]        win_size;
  logic [ADDR_W-1:0] win_addr;
  logic              win_illegal;

  // command latched at accept
  logic              l_write;
  logic              l_id;
  logic [1:0]        l_size;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;

  // registered response
  logic              rs_valid_q;
  logic              rs_id_q;
  logic              rs_err_q;
  logic [DATA_W-1:0] rs_rdata_q;

  // Size 3 is not a valid HSIZE for a 32-bit bus; halfword and word
  // accesses must be naturally aligned.
  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] a_lo);
    logic r;
    r = 1'b0;
    case (sz)
      2'd0:    r = 1'b0;
      2'd1:    r = a_lo[0];
      2'd2:    r = (a_lo != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Round-robin winner: a lone requester wins, on contention the one not
  // granted last time wins.
  always_comb begin
    any_req = |bus.rq_valid;
    win_id  = 1'b0;
    case (bus.rq_valid)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~last_grant;
      default: win_id = 1'b0;
    endcase
  end

  // Winner's command fields and legality, decoded ahead of the accept edge.
  always_comb begin
    win_size    = bus.rq_size[win_id];
    win_addr    = bus.rq_addr[win_id];
    win_illegal = is_illegal(win_size, win_addr[1:0]);
  end

  assign accept = (state == ST_IDLE) && any_req;

  // rq_ready is gated by rstn so it is forced low for the whole reset
  // period even if requesters already hold rq_valid.
  assign bus.rq_ready = (accept && rstn) ? (win_id ? 2'b10 : 2'b01) : 2'b00;

  // Next-state decode; ADDR and DATA each stall while the slave holds hready low.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = win_illegal ? ST_REJ : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.hready) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.hready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REJ:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant history; updated on every accept, rejected commands included.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= win_id;
    end
  end

  // Capture the winning command at the accept edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      l_write <= 1'b0;
      l_id    <= 1'b0;
      l_size  <= 2'd0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else if (accept) begin
      l_write <= bus.rq_write[win_id];
      l_id    <= win_id;
      l_size  <= win_size;
      l_addr  <= win_addr;
      l_wdata <= bus.rq_wdata[win_id];
    end
  end

  // Response capture: end of the data phase, or the cycle after a reject.
  // A first ERROR cycle arrives with hready low and is simply a wait here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs_valid_q <= 1'b0;
      rs_id_q    <= 1'b0;
      rs_err_q   <= 1'b0;
      rs_rdata_q <= '0;
    end else begin
      rs_valid_q <= 1'b0;
      if (state == ST_DATA && bus.hready) begin
        rs_valid_q <= 1'b1;
        rs_id_q    <= l_id;
        rs_err_q   <= bus.hresp;
        rs_rdata_q <= (!l_write && !bus.hresp) ? bus.hrdata : '0;
      end else if (state == ST_REJ) begin
        rs_valid_q <= 1'b1;
        rs_id_q    <= l_id;
        rs_err_q   <= 1'b1;
        rs_rdata_q <= '0;
      end
    end
  end

  // AHB address-phase signals come straight from the latched command; they
  // only matter while htrans is NONSEQ and are therefore stable across ADDR.
  assign bus.htrans = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr  = l_addr;
  assign bus.hwrite = l_write;
  assign bus.hsize  = {1'b0, l_size};
  assign bus.hwdata = (state == ST_DATA && l_write) ? l_wdata : '0;
  assign bus.hburst = 3'b000;
  assign bus.hprot  = 4'b0011;

  assign bus.rs_valid = rs_valid_q;
  assign bus.rs_id    = rs_id_q;
  assign bus.rs_err   = rs_err_q;
  assign bus.rs_rdata = rs_rdata_q;

  assign dbg_state = state;

endmodule
